// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch FSM: PC, fetch request, response latch.
// Define IFETCH_PERF_EN to add the o_fetch_cnt delivered-instruction counter.
module inst_fetch #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adv,
    input  logic              i_branch,
    input  logic [12:0]       i_br_off,
    output logic              o_i_req,
    output logic [ADDR_W-1:0] o_i_addr,
    input  logic              i_i_valid,
    input  logic [INST_W-1:0] i_i_inst,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       o_fetch_cnt,
`endif
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] br_off_ext;
    logic              capture;

    assign br_off_ext = {{(ADDR_W-13){i_br_off[12]}}, i_br_off};

    // Reset parks in REQ so the boot fetch from address 0 needs no advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= REQ;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_inst <= '0;
            o_pc   <= '0;
        end else if (capture) begin
            o_inst <= i_i_inst;
            o_pc   <= pc;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (i_adv) begin
                    pc_nxt    = i_branch ? (pc + br_off_ext) : (pc + ADDR_W'(4));
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (i_i_valid) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The request is masked while reset is held, since the state already sits in REQ.
    assign o_i_req      = (state == REQ) && i_rst_n;
    assign o_i_addr     = pc;
    assign o_inst_valid = (state == OUT);
    assign o_busy       = (state == REQ) || (state == WAIT);

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_cnt <= '0;
        end else if (state == OUT) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = fetch_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized bench for inst_fetch against a transaction-level PC model.
module tb_inst_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_adv;
    logic        i_branch;
    logic [12:0] i_br_off;
    logic        o_i_req;
    logic [63:0] o_i_addr;
    logic        i_i_valid;
    logic [31:0] i_i_inst;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [63:0] o_pc;
    logic        o_busy;
`ifdef IFETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          valid_pulses = 0;
    int          delivered = 0;
    logic [31:0] cnt_model = '0;
    logic [63:0] model_pc = '0;
    logic [31:0] last_inst = '0;
    logic [63:0] last_pc = '0;

    inst_fetch #(.ADDR_W(64), .INST_W(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_adv        (i_adv),
        .i_branch     (i_branch),
        .i_br_off     (i_br_off),
        .o_i_req      (o_i_req),
        .o_i_addr     (o_i_addr),
        .i_i_valid    (i_i_valid),
        .i_i_inst     (i_i_inst),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
`ifdef IFETCH_PERF_EN
        .o_fetch_cnt  (o_fetch_cnt),
`endif
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_inst_valid === 1'b1) valid_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Retire the current instruction from IDLE; the PC model follows the branch rules directly.
    task automatic advance(input bit taken, input logic [12:0] off);
        int off_i;
        i_adv    = 1'b1;
        i_branch = taken;
        i_br_off = off;
        tick();
        i_adv = 1'b0;
        off_i = int'(off);
        if (off[12]) off_i = off_i - 8192;
        if (taken) model_pc = model_pc + 64'(longint'(off_i));
        else       model_pc = model_pc + 64'd4;
    endtask

    // Called in the REQ cycle; returns in the IDLE cycle after delivery.
    task automatic do_fetch(input int lat, input logic [31:0] data, input bit noise);
        chk("req_pulse", o_i_req, 1);
        chk("req_addr", o_i_addr, model_pc);
        chk("req_busy", o_busy, 1);
        chk("req_no_valid", o_inst_valid, 0);
        i_i_valid = noise;
        i_i_inst  = ~data;
        tick();
        i_i_valid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk("wait_no_req", o_i_req, 0);
            chk("wait_busy", o_busy, 1);
            chk("wait_addr", o_i_addr, model_pc);
            chk("wait_no_valid", o_inst_valid, 0);
            i_adv    = noise;
            i_branch = 1'b1;
            i_br_off = 13'h0100;
            tick();
            i_adv = 1'b0;
        end
        chk("wait_last_busy", o_busy, 1);
        i_i_valid = 1'b1;
        i_i_inst  = data;
        tick();
        i_i_valid = 1'b0;
        i_i_inst  = $urandom;
        chk("out_valid", o_inst_valid, 1);
        chk("out_inst", o_inst, {32'h0, data});
        chk("out_pc", o_pc, model_pc);
        chk("out_not_busy", o_busy, 0);
        delivered++;
        cnt_model = cnt_model + 32'd1;
        last_inst = data;
        last_pc   = model_pc;
        i_i_valid = noise;
        i_adv     = noise;
        i_br_off  = 13'($urandom);
        tick();
        i_i_valid = 1'b0;
        i_adv     = 1'b0;
        chk("idle_valid_low", o_inst_valid, 0);
        chk("idle_inst_hold", o_inst, {32'h0, last_inst});
        chk("idle_pc_hold", o_pc, last_pc);
        chk("idle_addr", o_i_addr, model_pc);
        chk("idle_not_busy", o_busy, 0);
`ifdef IFETCH_PERF_EN
        chk("fetch_cnt", {32'h0, o_fetch_cnt}, {32'h0, cnt_model});
`endif
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_adv     = 1'b0;
        i_branch  = 1'b0;
        i_br_off  = '0;
        i_i_valid = 1'b0;
        i_i_inst  = '0;
        repeat (3) tick();
        chk("rst_req", o_i_req, 0);
        chk("rst_valid", o_inst_valid, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_addr", o_i_addr, 0);
`ifdef IFETCH_PERF_EN
        chk("rst_cnt", {32'h0, o_fetch_cnt}, 0);
`endif
        #2 i_rst_n = 1'b1;
        #1;

        // Boot fetch without any advance, L=1.
        do_fetch(1, 32'h0000_0013, 1'b0);

        // Walk to 0x10, then a not-taken advance to 0x14.
        for (int i = 0; i < 5; i++) begin
            advance(1'b0, 13'h0);
            do_fetch(1 + i, 32'h1000_0000 + i, 1'b0);
        end
        chk("pc_0x14", last_pc, 64'h14);

        // Back to 0, branch -4 wraps the PC, then not taken returns to 0.
        advance(1'b1, 13'h1FEC);
        do_fetch(2, 32'hAAAA_0001, 1'b0);
        advance(1'b1, 13'h1FFC);
        do_fetch(1, 32'hAAAA_0002, 1'b0);
        chk("wrap_addr", last_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        advance(1'b0, 13'h0);
        do_fetch(1, 32'hAAAA_0003, 1'b0);
        chk("wrap_back", last_pc, 64'h0);

        // Spurious advance and early response are ignored; L=5.
        advance(1'b0, 13'h0);
        do_fetch(5, 32'h5555_CAFE, 1'b1);
        chk("pulse_count", valid_pulses, delivered);

        // Randomized advances, latencies and noise.
        for (int i = 0; i < 30; i++) begin
            int idle_n;
            idle_n = int'($urandom_range(0, 3));
            for (int j = 0; j < idle_n; j++) begin
                i_i_valid = 1'($urandom);
                i_i_inst  = $urandom;
                tick();
                i_i_valid = 1'b0;
                chk("rnd_idle_req", o_i_req, 0);
                chk("rnd_idle_pc", o_pc, last_pc);
            end
            advance(1'($urandom), 13'($urandom));
            do_fetch(int'($urandom_range(1, 6)), $urandom, 1'($urandom));
        end
        chk("rnd_pulse_count", valid_pulses, delivered);

        // Reset during WAIT abandons the fetch and restarts at address 0.
        advance(1'b0, 13'h0);
        tick();
        chk("abandon_busy", o_busy, 1);
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        chk("abandon_req", o_i_req, 0);
        chk("abandon_pc", o_pc, 0);
        chk("abandon_inst", o_inst, 0);
        i_i_valid = 1'b1;
        i_i_inst  = 32'hDEAD_BEEF;
        repeat (2) tick();
        i_i_valid = 1'b0;
        chk("abandon_no_valid", valid_pulses, delivered);
        #2 i_rst_n = 1'b1;
        #1;
        model_pc  = '0;
        last_inst = '0;
        last_pc   = '0;
        cnt_model = '0;
`ifdef IFETCH_PERF_EN
        chk("cnt_after_rst", {32'h0, o_fetch_cnt}, 0);
`endif
        do_fetch(3, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 2; i++) begin
            advance(1'b0, 13'h0);
            do_fetch(2, 32'h7700_0000 + i, 1'b0);
        end
        chk("final_pulse_count", valid_pulses, delivered);
        chk("final_pc", last_pc, 64'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
